// File: rtl/if_stage_unit.sv
// if_stage_unit: instruction-fetch stage and IF/ID pipeline register of a
// 5-stage MIPS pipeline.
//
// The stage owns the PC and drives the instruction-memory address. It picks
// the next PC from the hazard unit's PCsrc/PCStall/IFstall/IFFlush controls.
// It also computes the branch and jump targets from the instruction that is
// latched in IF/ID, which is the instruction currently in ID.
//
// Optional feature: define PERF_CNT_EN to build the saturating stall, flush
// and fetch performance counters. When it is undefined the counter ports are
// tied to zero.
module if_stage_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       PCsrc,
  input  logic             PCStall,
  input  logic             IFstall,
  input  logic             IFFlush,
  input  logic [31:0]      imemData,
  output logic [31:0]      imemAddr,
  output logic [31:0]      IFIDinst,
  output logic [31:0]      IFIDpcPlus4,
  output logic             IFIDvalid,
  output logic [31:0]      branchTarget,
  output logic [31:0]      jumpTarget,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic [CNT_W-1:0] fetchCnt
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] branch_offset;

  // The 32-bit add wraps naturally, so 32'hFFFF_FFFC + 4 gives 0.
  assign pc_plus4 = pc + 32'd4;
  assign imemAddr = pc;

  // The targets come from the IF/ID contents, so they are ready while the
  // branch or jump sits in ID.
  assign branch_offset = {{14{IFIDinst[15]}}, IFIDinst[15:0], 2'b00};
  assign branchTarget  = IFIDpcPlus4 + branch_offset;
  assign jumpTarget    = {IFIDpcPlus4[31:28], IFIDinst[25:0], 2'b00};

  // Next-PC select. The encoding 2'b11 is not used and falls back to
  // sequential fetch.
  always_comb begin
    pc_next = pc_plus4;
    case (PCsrc)
      2'b00:   pc_next = branchTarget;
      2'b10:   pc_next = jumpTarget;
      default: pc_next = pc_plus4;
    endcase
  end

  // PC register. A stall holds the PC. A redirect that arrives during a stall
  // is taken once the stall is released.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc <= RESET_PC;
    end else if (!PCStall) begin
      pc <= pc_next;
    end
  end

  // IF/ID register. IFstall has priority over IFFlush, and IFFlush has
  // priority over a normal load. A flush loads a bubble, which is an sll nop
  // with valid cleared.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      IFIDinst    <= '0;
      IFIDpcPlus4 <= '0;
      IFIDvalid   <= 1'b0;
    end else if (!IFstall) begin
      IFIDpcPlus4 <= pc_plus4;
      if (IFFlush) begin
        IFIDinst  <= '0;
        IFIDvalid <= 1'b0;
      end else begin
        IFIDinst  <= imemData;
        IFIDvalid <= 1'b1;
      end
    end
  end

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] fetch_cnt;

  // Saturating event counters. Each one stops at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      fetch_cnt <= '0;
    end else begin
      if (PCStall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (IFFlush && !IFstall && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
      if (!IFstall && !IFFlush && (fetch_cnt != '1)) begin
        fetch_cnt <= fetch_cnt + CNT_ONE;
      end
    end
  end

  assign stallCnt = stall_cnt;
  assign flushCnt = flush_cnt;
  assign fetchCnt = fetch_cnt;
`else
  assign stallCnt = '0;
  assign flushCnt = '0;
  assign fetchCnt = '0;
`endif

endmodule

// File: tb/tb_if_stage_unit.sv
// Testbench for if_stage_unit. It drives directed stimulus with
// hand-computed expectations. After each clock edge the stimulus process
// pushes the expected results into a scoreboard queue. A separate monitor
// pops each entry on the falling edge and compares it with the DUT.
module tb_if_stage_unit;

  localparam int unsigned CW = 4;

  localparam int S_PC    = 0;
  localparam int S_INST  = 1;
  localparam int S_PC4   = 2;
  localparam int S_VALID = 3;
  localparam int S_BT    = 4;
  localparam int S_JT    = 5;
  localparam int S_STALL = 6;
  localparam int S_FLUSH = 7;
  localparam int S_FETCH = 8;

  localparam logic [31:0] JMP_END = 32'h0BFF_FFFF;  // j to end of current region

  logic          clk;
  logic          rstn;
  logic [1:0]    PCsrc;
  logic          PCStall;
  logic          IFstall;
  logic          IFFlush;
  logic [31:0]   imemData;
  logic [31:0]   imemAddr;
  logic [31:0]   IFIDinst;
  logic [31:0]   IFIDpcPlus4;
  logic          IFIDvalid;
  logic [31:0]   branchTarget;
  logic [31:0]   jumpTarget;
  logic [CW-1:0] stallCnt;
  logic [CW-1:0] flushCnt;
  logic [CW-1:0] fetchCnt;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        q[$];
  chk_t        mc;
  logic [31:0] act;
  int          tests = 0;
  int          fails = 0;

  if_stage_unit #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .PCsrc       (PCsrc),
    .PCStall     (PCStall),
    .IFstall     (IFstall),
    .IFFlush     (IFFlush),
    .imemData    (imemData),
    .imemAddr    (imemAddr),
    .IFIDinst    (IFIDinst),
    .IFIDpcPlus4 (IFIDpcPlus4),
    .IFIDvalid   (IFIDvalid),
    .branchTarget(branchTarget),
    .jumpTarget  (jumpTarget),
    .stallCnt    (stallCnt),
    .flushCnt    (flushCnt),
    .fetchCnt    (fetchCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model. It holds a few fixed instructions. The start of
  // each region (except regions 0 and 4) holds a jump to the end of that
  // region. Every other address returns addi-like filler that encodes the
  // address in the low half of the word.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_0004: return 32'h2002_0001;
      32'h0000_0008: return 32'h2003_0002;
      32'h0000_000C: return 32'h1000_0003;  // beq imm 3
      32'h0000_001C,
      32'h0000_00A4,
      32'h4000_0100: return JMP_END;
      32'h4000_0004: return 32'h0800_0040;  // j 0x40
      default: begin
        if ((a[27:0] == 28'h0) && (a[31:28] != 4'h0) && (a[31:28] != 4'h4))
          return JMP_END;
        return {16'h2000, a[15:0]};
      end
    endcase
  endfunction

  always_comb imemData = imem(imemAddr);

  function automatic logic [31:0] cexp(input int v);
`ifdef PERF_CNT_EN
    return (v > 15) ? 32'd15 : 32'(v);
`else
    return (v >= 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_PC:    return imemAddr;
      S_INST:  return IFIDinst;
      S_PC4:   return IFIDpcPlus4;
      S_VALID: return {31'd0, IFIDvalid};
      S_BT:    return branchTarget;
      S_JT:    return jumpTarget;
      S_STALL: return 32'(stallCnt);
      S_FLUSH: return 32'(flushCnt);
      default: return 32'(fetchCnt);
    endcase
  endfunction

  // Monitor: on each falling edge, drain the scoreboard and compare.
  always @(negedge clk) begin
    while (q.size() != 0) begin
      mc  = q.pop_front();
      act = actual(mc.sel);
      tests = tests + 1;
      if (act !== mc.exp) begin
        fails = fails + 1;
        $display("FAIL %s: got %h, expected %h", mc.name, act, mc.exp);
      end
    end
  end

  task automatic push(input string nm, input int sel, input logic [31:0] e);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.exp  = e;
    q.push_back(c);
  endtask

  task automatic exp_st(input string nm, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] pc4, input logic valid);
    push({nm, ".pc"}, S_PC, pc);
    push({nm, ".inst"}, S_INST, inst);
    push({nm, ".pc4"}, S_PC4, pc4);
    push({nm, ".valid"}, S_VALID, {31'd0, valid});
  endtask

  task automatic exp_cnt(input string nm, input int st, input int fl, input int fe);
    push({nm, ".stallCnt"}, S_STALL, cexp(st));
    push({nm, ".flushCnt"}, S_FLUSH, cexp(fl));
    push({nm, ".fetchCnt"}, S_FETCH, cexp(fe));
  endtask

  task automatic step(input logic [1:0] src, input logic ps, input logic is,
                      input logic fl, input logic rn);
    PCsrc   = src;
    PCStall = ps;
    IFstall = is;
    IFFlush = fl;
    rstn    = rn;
    @(posedge clk);
    #1;
  endtask

  // A hop fetches the jump at s and takes it to the end of region r. It then
  // falls through sequentially into region r+1.
  task automatic hop(input logic [31:0] s, input int unsigned r);
    logic [31:0] rb;
    rb = 32'(r) << 28;
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("hop_fetch", s + 32'd4, JMP_END, s + 32'd4, 1'b1);
    step(2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_st("hop_jump", rb | 32'h0FFF_FFFC, 32'h0, s + 32'd8, 1'b0);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("hop_wrap", rb + 32'h1000_0000, 32'h2000_FFFC, rb + 32'h1000_0000, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; PCsrc = 2'b01; PCStall = 1'b0; IFstall = 1'b0; IFFlush = 1'b0;

    // Reset for two cycles, then free-run sequential fetch.
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    push("reset1.pc", S_PC, 32'h0);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_st("reset2", 32'h0, 32'h0, 32'h0, 1'b0);
    exp_cnt("reset2", 0, 0, 0);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("fetch1", 32'h4, 32'h2001_0005, 32'h4, 1'b1);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("fetch2", 32'h8, 32'h2002_0001, 32'h8, 1'b1);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("fetch3", 32'hC, 32'h2003_0002, 32'hC, 1'b1);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("fetch_beq", 32'h10, 32'h1000_0003, 32'h10, 1'b1);
    push("beq.branchTarget", S_BT, 32'h1C);
    exp_cnt("fetch4", 0, 0, 4);

    // Taken branch: redirect to 0x1C and insert a bubble.
    step(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_st("branch", 32'h1C, 32'h0, 32'h14, 1'b0);
    exp_cnt("branch", 0, 1, 4);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("fetch_j", 32'h20, JMP_END, 32'h20, 1'b1);
    push("j0.jumpTarget", S_JT, 32'h0FFF_FFFC);

    // Load-use stall at PC 0x20.
    step(2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_st("stall", 32'h20, JMP_END, 32'h20, 1'b1);
    exp_cnt("stall", 1, 1, 5);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("resume", 32'h24, 32'h2000_0020, 32'h24, 1'b1);
    exp_cnt("resume", 1, 1, 6);

    // Stall plus flush with a branch redirect: the stall wins.
    step(2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_st("stall_flush", 32'h24, 32'h2000_0020, 32'h24, 1'b1);
    push("stall_flush.branchTarget", S_BT, 32'hA4);
    exp_cnt("stall_flush", 2, 1, 6);
    step(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_st("flush_after", 32'hA4, 32'h0, 32'h28, 1'b0);
    exp_cnt("flush_after", 2, 2, 6);

    // Hop across regions 0..3 to reach 0x4000_0000.
    hop(32'hA4, 0);
    push("neg_imm.branchTarget", S_BT, 32'h0FFF_FFF0);
    exp_cnt("hop0", 2, 3, 8);
    for (int unsigned r = 1; r <= 3; r++) hop(32'(r) << 28, r);

    // Jump with the upper PC nibble preserved.
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("r4_fetch0", 32'h4000_0004, 32'h2000_0000, 32'h4000_0004, 1'b1);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("r4_fetch_j", 32'h4000_0008, 32'h0800_0040, 32'h4000_0008, 1'b1);
    push("r4.jumpTarget", S_JT, 32'h4000_0100);
    step(2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_st("r4_jump", 32'h4000_0100, 32'h0, 32'h4000_000C, 1'b0);
    exp_cnt("r4_jump", 2, 7, 16);

    // Continue to region F, then wrap from 0xFFFF_FFFC.
    hop(32'h4000_0100, 4);
    for (int unsigned r = 5; r <= 14; r++) hop(32'(r) << 28, r);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("rF_fetch", 32'hF000_0004, JMP_END, 32'hF000_0004, 1'b1);
    step(2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_st("rF_jump", 32'hFFFF_FFFC, 32'h0, 32'hF000_0008, 1'b0);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("wrap", 32'h0, 32'h2000_FFFC, 32'h0, 1'b1);
    exp_cnt("wrap_sat", 2, 19, 40);

    // Reset while a stall and a flush are both asserted.
    step(2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_st("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
    exp_cnt("rst_stall", 0, 0, 0);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_st("post_rst", 32'h4, 32'h2001_0005, 32'h4, 1'b1);
    exp_cnt("post_rst", 0, 0, 1);

    @(negedge clk);
    #1;
    tests = tests + 1;
    if (q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage_unit.md
Name: if_stage_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC from the hazard unit's PCsrc, PCStall, IFstall and IFFlush controls.
- Computes branch and jump targets from the instruction currently latched in IF/ID and feeds ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the performance counters (used only with PERF_CNT_EN).

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  synchronous active-low reset.
- PCsrc  in  2  next-PC select: 00 branch target, 01 PC+4, 10 jump target, 11 treated as PC+4.
- PCStall  in  1  hold PC.
- IFstall  in  1  hold IF/ID register.
- IFFlush  in  1  load a bubble into IF/ID.
- imemData  in  32  instruction read combinationally at imemAddr.
- imemAddr  out  32  current PC.
- IFIDinst  out  32  latched instruction.
- IFIDpcPlus4  out  32  latched PC+4.
- IFIDvalid  out  1  IF/ID holds a real instruction (0 = bubble).
- branchTarget  out  32  IFIDpcPlus4 + (sign-extended IFIDinst[15:0] << 2).
- jumpTarget  out  32  {IFIDpcPlus4[31:28], IFIDinst[25:0], 2'b00}.
- stallCnt  out  CNT_W  cycles with PCStall=1.
- flushCnt  out  CNT_W  cycles in which a flush was applied.
- fetchCnt  out  CNT_W  instructions accepted into IF/ID with valid=1.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - PC <= RESET_PC.
  - IFIDinst <= 0 (sll nop), IFIDpcPlus4 <= 0, IFIDvalid <= 0.
  - All counters <= 0.
  - Reset overrides every other input, including mid-stall and mid-flush.
- PC register, each edge when not in reset:
  - If PCStall=1, PC holds.
  - Else PC <= mux(PCsrc): 00 branchTarget, 01 PC+4, 10 jumpTarget, 11 PC+4.
  - PC+4 uses 32-bit modular add; 32'hFFFF_FFFC + 4 wraps to 0.
- IF/ID register, priority IFstall > IFFlush > load:
  - IFstall=1: all IF/ID fields hold. A simultaneous IFFlush is ignored this cycle; the hazard unit re-asserts it once the stall clears.
  - IFFlush=1 (no stall): IFIDinst <= 0, IFIDvalid <= 0, IFIDpcPlus4 <= PC+4.
  - Otherwise: IFIDinst <= imemData, IFIDpcPlus4 <= PC+4, IFIDvalid <= 1.
- Targets:
  - branchTarget and jumpTarget are purely combinational from IF/ID contents.
  - They are valid in the same cycle the instruction sits in ID.
  - Branch resolution is therefore one cycle after fetch, and a taken branch or jump costs exactly one bubble.
- Simultaneous load-use and branch/jump:
  - The hazard unit asserts PCStall and IFstall together with a redirect PCsrc.
  - The stall wins: PC and IF/ID hold, and the redirect is taken on the next non-stalled cycle.
- PCStall=1 with IFstall=0 is not produced by the hazard unit. If it occurs, IF/ID loads the instruction at the held PC again; this is not flagged as an error.
- Latency: the instruction at PC appears on IFIDinst one cycle later, absent stall or flush.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - stallCnt increments on every non-reset edge with PCStall=1.
  - flushCnt increments when IFFlush=1 and IFstall=0.
  - fetchCnt increments when IF/ID loads with valid=1.
  - All counters saturate at all-ones and never wrap.
- Not defined:
  - The counter registers are not built.
  - stallCnt, flushCnt and fetchCnt are tied to 0; ports are still present.

Test Plan:
- Reset then free run:
  - Stimulus: rstn low 2 cycles, RESET_PC=0, PCsrc=01, no stall or flush; imem returns 32'h2001_0005 at address 0.
  - Required: imemAddr = 0, 4, 8 on successive cycles; the cycle after release gives IFIDinst=32'h2001_0005, IFIDpcPlus4=4, IFIDvalid=1.
- Taken branch:
  - Stimulus: IF/ID holds beq with imm 16'h0003 and IFIDpcPlus4=32'h10; drive PCsrc=00 and IFFlush=1 for one cycle.
  - Required: branchTarget=32'h1C; next edge PC=32'h1C, IFIDvalid=0, IFIDinst=0.
- Jump:
  - Stimulus: IFIDinst=32'h0800_0040, IFIDpcPlus4=32'h4000_0008; PCsrc=10, IFFlush=1.
  - Required: jumpTarget=32'h4000_0100; PC loads 32'h4000_0100; a bubble enters IF/ID.
- Load-use stall:
  - Stimulus: PCStall=IFstall=1 for 1 cycle at PC=32'h20.
  - Required: PC stays 32'h20, all IF/ID fields unchanged; next cycle normal fetch resumes; stallCnt=1 with PERF_CNT_EN.
- Stall plus flush:
  - Stimulus: IFstall=PCStall=IFFlush=1 with PCsrc=00.
  - Required: no PC change, IF/ID held, flushCnt unchanged; the following cycle with stall=0 and flush=1 redirects PC and inserts the bubble.
- Wrap and reset mid-stall:
  - Stimulus: PC=32'hFFFF_FFFC with PCsrc=01, then the next cycle assert rstn=0 while PCStall=1.
  - Required: PC becomes 0, then RESET_PC; IFIDvalid=0; counters cleared.
